// File: rtl/bt_uart_rx.sv
// Serial byte receiver for the Bluetooth UART link: synchronises rx, qualifies the start
// bit, shifts in 8 data bits LSB-first, checks the stop bit, holds the byte with a ready level.
module bt_uart_rx #(
    parameter int unsigned START_CLKS  = 16,
    parameter int unsigned BIT_CLKS    = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       ready
);

    localparam int unsigned MAX_CLKS = (START_CLKS > BIT_CLKS) ? START_CLKS : BIT_CLKS;
    localparam int unsigned CNT_W    = $clog2(MAX_CLKS) + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [7:0]               shift_q, shift_d;
    logic [7:0]               data_q, data_d;
    logic                     ready_q, ready_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     rx_s;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign data_out = data_q;
    assign ready    = ready_q;

    // Synchroniser chain; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= SYNC_STAGES'({sync_q, rx});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ready_d   = ready_q;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = CNT_W'(1);
                    ready_d = 1'b0;
                end
            end
            START: begin
                if (rx_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(START_CLKS - 1)) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(BIT_CLKS / 2)) begin
                    shift_d[bit_idx_q] = rx_s;
                end
                if (cnt_q == CNT_W'(BIT_CLKS - 1)) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_W'(BIT_CLKS / 2)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_IDLE: begin
                // A line stuck low must not be taken as a fresh start bit.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_bt_uart_rx.sv
// Directed self-checking bench for bt_uart_rx (START_CLKS=16, BIT_CLKS=1, SYNC_STAGES=2).
module tb_bt_uart_rx;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] data_out;
    logic       ready;

    int n_cmp  = 0;
    int n_fail = 0;

    bt_uart_rx #(
        .START_CLKS (16),
        .BIT_CLKS   (1),
        .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .data_out(data_out),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start bit for 16 clocks, 8 data bits LSB-first, then the given stop level.
    // Returns 1 time unit after the edge on which the stop level is first sampled by the input flop.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(1);
        end
        rx = stop_bit;
        tick(1);
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        #2;
        chk("rst_data", data_out, 8'h00);
        chk("rst_ready", {7'd0, ready}, 8'h00);
        tick(1);
        reset = 1'b0;
        tick(10);
        chk("idle_data", data_out, 8'h00);
        chk("idle_ready", {7'd0, ready}, 8'h00);

        // 0xAA: ready rises two edges after the stop bit enters the synchroniser
        send_frame(8'hAA, 1'b1);
        tick(1);
        chk("aa_ready_early", {7'd0, ready}, 8'h00);
        tick(1);
        chk("aa_ready", {7'd0, ready}, 8'h01);
        chk("aa_data", data_out, 8'hAA);
        tick(20);
        chk("aa_hold_ready", {7'd0, ready}, 8'h01);
        chk("aa_hold_data", data_out, 8'hAA);

        // 0x55: ready drops at the start bit, data_out kept until the new stop bit
        rx = 1'b0;
        tick(4);
        chk("55_ready_drop", {7'd0, ready}, 8'h00);
        chk("55_data_kept", data_out, 8'hAA);
        rx = 1'b1;
        tick(20);
        send_frame(8'h55, 1'b1);
        rx = 1'b1;
        tick(20);
        chk("55_ready", {7'd0, ready}, 8'h01);
        chk("55_data", data_out, 8'h55);

        // Short low pulse: start qualified too briefly, no byte
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(30);
        chk("glitch_ready", {7'd0, ready}, 8'h00);
        chk("glitch_data", data_out, 8'h55);

        // Framing error: stop bit low and line held low afterwards
        send_frame(8'h3C, 1'b0);
        tick(5);
        chk("ferr_ready", {7'd0, ready}, 8'h00);
        chk("ferr_data", data_out, 8'h55);
        tick(40);
        chk("ferr_low_ready", {7'd0, ready}, 8'h00);
        chk("ferr_low_data", data_out, 8'h55);
        rx = 1'b1;
        tick(20);
        chk("ferr_high_ready", {7'd0, ready}, 8'h00);
        chk("ferr_high_data", data_out, 8'h55);
        send_frame(8'h0F, 1'b1);
        rx = 1'b1;
        tick(20);
        chk("0f_ready", {7'd0, ready}, 8'h01);
        chk("0f_data", data_out, 8'h0F);

        // Asynchronous reset in the middle of the data bits
        rx = 1'b0;
        tick(16);
        rx = 1'b1;
        tick(1);
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(1);
        chk("mid_data_before", data_out, 8'h0F);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_data", data_out, 8'h00);
        chk("mid_rst_ready", {7'd0, ready}, 8'h00);
        tick(2);
        reset = 1'b0;
        rx    = 1'b1;
        tick(10);
        chk("post_rst_ready", {7'd0, ready}, 8'h00);
        send_frame(8'hC3, 1'b1);
        rx = 1'b1;
        tick(20);
        chk("c3_ready", {7'd0, ready}, 8'h01);
        chk("c3_data", data_out, 8'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
